uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter UART_BPS, default 9600, giving the serial baud rate.
REQ-002 The block SHALL have parameter CLK_FREQ, default 50_000_000, giving the sys_clk frequency in Hz.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, giving the input buffer depth in bytes (power of two, 2..64).
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port sys_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port pi_data, input, 8 bits: the byte to transmit.
REQ-007 The block SHALL have port pi_flag, input, 1 bit: a one-cycle write strobe for pi_data.
REQ-008 The block SHALL have port tx, output, 1 bit: serial line, 8N1, LSB first, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is on the line or the FIFO is non-empty.
REQ-010 The block SHALL have port fifo_full, output, 1 bit: high when the FIFO holds FIFO_DEPTH bytes.
REQ-011 The block SHALL have port overflow, output, 1 bit: a one-cycle pulse when a write is dropped.

Function
REQ-012 BAUD_CNT_MAX SHALL be CLK_FREQ/UART_BPS using integer division (5208 at the defaults); each bit SHALL last exactly BAUD_CNT_MAX cycles.
REQ-013 The baud counter width SHALL be $clog2(BAUD_CNT_MAX); the counter SHALL count from 0 to BAUD_CNT_MAX-1 and wrap only while in a non-IDLE state, holding at 0 in IDLE.
REQ-014 The FSM states SHALL be IDLE, START, DATA and STOP.
REQ-015 IDLE SHALL go to START when the FIFO is non-empty: the head byte is popped into the shift register and tx drives 0.
REQ-016 START SHALL go to DATA on baud wrap, with bit_cnt=0.
REQ-017 In DATA, tx SHALL equal shift[0]; on each baud wrap the register shifts right and bit_cnt increments; after bit 7 wraps, the FSM goes to STOP.
REQ-018 STOP SHALL drive tx=1 for one bit period; on wrap it SHALL go to START, popping the next byte in the same cycle, if the FIFO is non-empty, and otherwise to IDLE. There SHALL be no idle gap between back-to-back frames.
REQ-019 Frame length SHALL be 10*BAUD_CNT_MAX cycles.
REQ-020 tx SHALL be a registered output with no combinational path from any input.
REQ-021 Latency: with the block in IDLE and the FIFO empty, a pi_flag sampled at edge N SHALL cause tx to fall at edge N+2.
REQ-022 A write with fifo_full=0 SHALL be accepted; a write with fifo_full=1 SHALL be dropped and overflow SHALL pulse at edge N+1. This SHALL hold even if a pop occurs in the same cycle.
REQ-023 A simultaneous push and pop when not full SHALL leave the occupancy unchanged and lose no data.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with a counter of width $clog2(FIFO_DEPTH)+1.
REQ-025 busy SHALL be (state!=IDLE) || (count!=0), registered.
REQ-026 A pi_flag held high for k cycles SHALL be treated as k writes.

Reset
REQ-027 On sys_rst the block SHALL set tx=1, busy=0, fifo_full=0, overflow=0, state=IDLE, all counters and pointers=0 and the shift register=0.
REQ-028 A reset asserted mid-frame SHALL abort the frame immediately, with tx forced high asynchronously and FIFO contents discarded.
REQ-029 After reset deassertion, the first frame SHALL begin no earlier than the edge following the first accepted write.

Structure
REQ-030 A shared package uart_pkg SHALL hold the state enumeration (IDLE, START, DATA, STOP), the default UART_BPS and CLK_FREQ, and the baud-count function.
REQ-031 The FIFO SHALL be the single sub-module, uart_tx_fifo_buf, parameterised by depth and width 8, with ports wr_en, din, rd_en, dout, count, full and empty.
REQ-032 The FSM, baud counter and shift register SHALL stay in the top module.

Verification
REQ-033 Single byte: pi_data=0x55, one pi_flag -> tx low at N+2, then bits 1,0,1,0,1,0,1,0, then stop high, each 5208 cycles; busy drops after 52080 cycles.
REQ-034 Back-to-back: 0xA3, 0x00, 0xFF on three consecutive cycles -> three contiguous frames with no gap; total line time 156240 cycles; the bit patterns match LSB first.
REQ-035 Overflow: 10 consecutive writes while IDLE -> the first byte starts transmitting and 8 are buffered, fifo_full asserts, and the 10th write pulses overflow once and is never transmitted.
REQ-036 Reset mid-frame: sys_rst during DATA bit 3 of 0x3C with 4 bytes queued -> tx=1 immediately, busy=0, and no further frames after release.
REQ-037 Loopback: tx feeds the team's existing 9600-baud 50 MHz receiver and 256 random bytes are sent -> all 256 received in order and intact.
REQ-038 Parameter sweep: UART_BPS=115200 -> BAUD_CNT_MAX=434, and the bit period is measured as exactly 434 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, default line settings
// and the baud divider helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int DEF_UART_BPS = 9600;
    localparam int DEF_CLK_FREQ = 50_000_000;

    function automatic int baud_cnt_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Byte FIFO in front of the UART transmitter. The head word is visible on
// dout without a read, so a pop can load the shift register in the same cycle.
module uart_tx_fifo_buf #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A write while full is dropped even if a pop frees a slot this cycle.
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: input register, byte FIFO, and a
// START/DATA/STOP framer with back-to-back frame support.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int UART_BPS   = DEF_UART_BPS,
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] pi_data,
    input  logic       pi_flag,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int CW           = $clog2(BAUD_CNT_MAX);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT_MAX - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud_cnt;
    logic          baud_wrap;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic [7:0]    head;
    logic [7:0]    din_q;
    logic          wr_q;
    logic          pop;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          tx_next;
    logic          busy_next;

    uart_tx_fifo_buf #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_buf (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .wr_en (wr_q),
        .din   (din_q),
        .rd_en (pop),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign fifo_full = full;
    assign baud_wrap = (state != IDLE) && (baud_cnt == BAUD_LAST);

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        pop          = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    state_next = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    shift_next   = {1'b0, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line level and busy are computed for the state being entered, so the
    // registered outputs line up with the state register.
    always_comb begin
        tx_next = 1'b1;
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE) || (count != '0) || wr_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
            wr_q     <= 1'b0;
            din_q    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= (state == IDLE || baud_wrap) ? '0 : baud_cnt + CW'(1);
            bit_cnt  <= bit_cnt_next;
            shift    <= shift_next;
            tx       <= tx_next;
            busy     <= busy_next;
            overflow <= wr_q && full;
            wr_q     <= pi_flag;
            din_q    <= pi_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: serial decoder against queued bytes,
// plus latency, overflow, reset and bit-period checks.
module tb_uart_tx_fifo;

    localparam int B  = 1_000_000 / 100_000;
    localparam int B2 = 50_000_000 / 115200;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;
    logic [7:0] data2;
    logic       flag2;
    logic       tx2;
    logic       busy2;
    logic       full2;
    logic       ovf2;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         frames = 0;
    logic [7:0] sb[$];
    int         starts[$];

    uart_tx_fifo #(
        .UART_BPS   (100_000),
        .CLK_FREQ   (1_000_000),
        .FIFO_DEPTH (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .pi_data   (pi_data),
        .pi_flag   (pi_flag),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    uart_tx_fifo #(
        .UART_BPS   (115200),
        .CLK_FREQ   (50_000_000),
        .FIFO_DEPTH (8)
    ) dut_fast (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .pi_data   (data2),
        .pi_flag   (flag2),
        .tx        (tx2),
        .busy      (busy2),
        .fifo_full (full2),
        .overflow  (ovf2)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial decoder: samples mid-bit, pops the scoreboard at each stop bit.
    bit         rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = '0;
    logic [7:0] rx_exp;
    int         rx_k;

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
                starts.push_back(cyc);
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= B / 2 && (rx_cnt - B / 2) % B == 0) begin
                rx_k = (rx_cnt - B / 2) / B;
                if (rx_k == 0) begin
                    chk("start_bit", tx, 0);
                end else if (rx_k <= 8) begin
                    rx_byte[rx_k-1] = tx;
                end else begin
                    chk("stop_bit", tx, 1);
                    rx_act = 1'b0;
                    frames++;
                    chk("rx_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        rx_exp = sb.pop_front();
                        chk("rx_byte", rx_byte, rx_exp);
                    end
                end
            end
        end
    end

    task automatic wr_byte(input logic [7:0] d);
        pi_flag = 1'b1;
        pi_data = d;
        sb.push_back(d);
        @(negedge sys_clk);
        pi_flag = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int t);
        int i;
        i = 0;
        while (busy && i < limit) begin
            @(negedge sys_clk);
            i++;
        end
        chk("idle_wait", busy, 0);
        t = cyc;
    endtask

    initial begin
        int n;
        int t;
        int f0;
        int j;
        int lows;
        int fall;
        logic [7:0] d;

        sys_rst = 1'b1;
        pi_flag = 1'b0;
        pi_data = '0;
        flag2   = 1'b0;
        data2   = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", overflow, 0);
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("idle_tx", tx, 1);

        // single byte and write-to-line latency
        wr_byte(8'h55);
        n = cyc;
        chk("lat_n0", tx, 1);
        @(negedge sys_clk);
        chk("lat_n1", tx, 1);
        chk("busy_on", busy, 1);
        @(negedge sys_clk);
        chk("lat_n2", tx, 0);
        wait_idle(400, t);
        chk("single_len", t - n, 2 + 10 * B);
        chk("single_sb", sb.size(), 0);

        // back-to-back frames without gaps
        repeat (5) @(negedge sys_clk);
        starts.delete();
        wr_byte(8'hA3);
        n = cyc;
        wr_byte(8'h00);
        wr_byte(8'hFF);
        wait_idle(800, t);
        chk("b2b_len", t - n, 2 + 30 * B);
        chk("b2b_starts", starts.size(), 3);
        if (starts.size() >= 3) begin
            chk("b2b_first", starts[0] - n, 2);
            chk("b2b_gap1", starts[1] - starts[0], 10 * B);
            chk("b2b_gap2", starts[2] - starts[1], 10 * B);
        end
        chk("b2b_sb", sb.size(), 0);

        // overflow: ten writes, nine kept
        repeat (5) @(negedge sys_clk);
        f0 = frames;
        n = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            d = 8'h10 + 8'(i);
            pi_flag = 1'b1;
            pi_data = d;
            if (i < 9) sb.push_back(d);
            @(negedge sys_clk);
            if (i == 8) chk("full_early", fifo_full, 0);
            if (i == 9) begin
                chk("full_set", fifo_full, 1);
                chk("ovf_early", overflow, 0);
            end
        end
        pi_flag = 1'b0;
        @(negedge sys_clk);
        chk("ovf_pulse", overflow, 1);
        chk("full_hold", fifo_full, 1);
        @(negedge sys_clk);
        chk("ovf_clear", overflow, 0);
        wait_idle(1500, t);
        chk("ovf_len", t - n, 2 + 90 * B);
        chk("ovf_frames", frames - f0, 9);
        chk("ovf_sb", sb.size(), 0);

        // reset during data bit 3 with bytes queued
        repeat (5) @(negedge sys_clk);
        f0 = frames;
        wr_byte(8'h3C);
        n = cyc;
        for (int i = 0; i < 4; i++) wr_byte(8'($urandom));
        while (cyc < n + 2 + 4 * B + B / 2) @(negedge sys_clk);
        chk("pre_rst_busy", busy, 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_full", fifo_full, 0);
        sb.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        lows = 0;
        repeat (30 * B) begin
            @(negedge sys_clk);
            if (!tx) lows++;
        end
        chk("post_rst_quiet", lows, 0);
        chk("post_rst_busy", busy, 0);
        chk("rst_frames", frames - f0, 0);

        // random stream paced on fifo_full
        f0 = frames;
        for (int i = 0; i < 20; i++) begin
            j = 0;
            while (fifo_full && j < 2000) begin
                @(negedge sys_clk);
                j++;
            end
            wr_byte(8'($urandom));
            @(negedge sys_clk);
        end
        wait_idle(3000, t);
        chk("rand_frames", frames - f0, 20);
        chk("rand_sb", sb.size(), 0);

        // 115200 baud instance: measure one bit period
        data2 = 8'h01;
        flag2 = 1'b1;
        @(negedge sys_clk);
        flag2 = 1'b0;
        n = cyc;
        j = 0;
        while (tx2 && j < 10) begin
            @(negedge sys_clk);
            j++;
        end
        chk("fast_lat", cyc - n, 2);
        fall = cyc;
        j = 0;
        while (!tx2 && j < 1000) begin
            @(negedge sys_clk);
            j++;
        end
        chk("fast_bit", cyc - fall, B2);
        j = 0;
        while (busy2 && j < 6000) begin
            @(negedge sys_clk);
            j++;
        end
        chk("fast_idle", busy2, 0);
        chk("fast_line", tx2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
